apb_fsm_controller: RTL and testbench

APB_FSM_CONTROLLER -- requirements
Module: apb_fsm_controller

---
 rtl/apb_fsm_controller.sv | 207 ++++++++++++++++++++
 tb/tb_apb_fsm_controller.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_fsm_controller.sv
// apb_fsm_controller: AHB-to-APB bridge control FSM. Turns qualified AHB
// transfers into APB setup/enable phases and returns hreadyout upstream.
//
// Ports:
//   hclk, hreset       clock, synchronous active-high reset
//   valid              qualified AHB transfer request
//   haddr/1/2          current, 1-cycle and 2-cycle delayed address
//   hwdata/1           current and 1-cycle delayed write data
//   hwrite/hwrite_reg  current and 1-cycle delayed write flag
//   temp_selx          one-hot peripheral select decoded from haddr
//   pready             APB slave ready (used only with APB_PREADY_EN)
//   pselx, penable, pwrite, paddr, pwdata   registered APB master outputs
//   hreadyout          registered ready back to the AHB master
//
// Build option: define APB_PREADY_EN to let the enable states wait on
// pready; without it every enable phase lasts exactly one cycle.

module apb_fsm_controller #(
    parameter int ADDR_W = 32
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              valid,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [ADDR_W-1:0] haddr1,
    input  logic [ADDR_W-1:0] haddr2,
    input  logic [ADDR_W-1:0] hwdata,
    input  logic [ADDR_W-1:0] hwdata1,
    input  logic              hwrite,
    input  logic              hwrite_reg,
    input  logic [2:0]        temp_selx,
    input  logic              pready,
    output logic [2:0]        pselx,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [ADDR_W-1:0] pwdata,
    output logic              hreadyout
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_READ     = 3'd1,
        ST_RENABLE  = 3'd2,
        ST_WWAIT    = 3'd3,
        ST_WRITE    = 3'd4,
        ST_WENABLE  = 3'd5,
        ST_WRITEP   = 3'd6,
        ST_WENABLEP = 3'd7
    } state_t;

    state_t              r_state;
    state_t              w_next;
    state_t              w_req_next;

    logic [2:0]          r_pselx;
    logic                r_penable;
    logic                r_pwrite;
    logic [ADDR_W-1:0]   r_paddr;
    logic [ADDR_W-1:0]   r_pwdata;
    logic                r_hreadyout;

    logic [2:0]          w_pselx;
    logic                w_penable;
    logic                w_pwrite;
    logic [ADDR_W-1:0]   w_paddr;
    logic [ADDR_W-1:0]   w_pwdata;
    logic                w_hreadyout;

    logic                w_pready_ok;
    logic                w_en_hready;

`ifdef APB_PREADY_EN
    // Enable phases complete only when the slave is ready; the AHB side
    // is stalled for the whole enable phase until that happens.
    assign w_pready_ok = pready;
    assign w_en_hready = 1'b0;
`else
    logic w_unused_pready;
    assign w_unused_pready = pready;
    assign w_pready_ok     = 1'b1;
    assign w_en_hready     = 1'b1;
`endif

    // Next state
    always_comb begin
        w_req_next = ST_IDLE;
        w_next     = r_state;
        if (valid) begin
            w_req_next = hwrite ? ST_WWAIT : ST_READ;
        end
        unique case (r_state)
            ST_IDLE: begin
                w_next = w_req_next;
            end
            ST_RENABLE, ST_WENABLE: begin
                w_next = w_pready_ok ? w_req_next : r_state;
            end
            ST_READ: begin
                w_next = ST_RENABLE;
            end
            ST_WWAIT: begin
                w_next = valid ? ST_WRITEP : ST_WRITE;
            end
            ST_WRITE: begin
                w_next = valid ? ST_WENABLEP : ST_WENABLE;
            end
            ST_WRITEP: begin
                w_next = ST_WENABLEP;
            end
            ST_WENABLEP: begin
                if (!w_pready_ok) begin
                    w_next = ST_WENABLEP;
                end else if (!hwrite_reg) begin
                    w_next = ST_READ;
                end else if (valid) begin
                    w_next = ST_WRITEP;
                end else begin
                    w_next = ST_WRITE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Output values are chosen by the state being entered, so the APB
    // signals are already stable for the whole of that state.
    always_comb begin
        w_pselx     = r_pselx;
        w_penable   = r_penable;
        w_pwrite    = r_pwrite;
        w_paddr     = r_paddr;
        w_pwdata    = r_pwdata;
        w_hreadyout = r_hreadyout;
        unique case (w_next)
            ST_IDLE, ST_WWAIT: begin
                w_pselx     = 3'b000;
                w_penable   = 1'b0;
                w_hreadyout = 1'b1;
            end
            ST_READ: begin
                w_paddr     = haddr;
                w_pwrite    = 1'b0;
                w_pselx     = temp_selx;
                w_penable   = 1'b0;
                w_hreadyout = 1'b0;
            end
            ST_WRITE: begin
                w_paddr     = haddr1;
                w_pwdata    = hwdata;
                w_pwrite    = 1'b1;
                w_pselx     = temp_selx;
                w_penable   = 1'b0;
                w_hreadyout = 1'b1;
            end
            ST_WRITEP: begin
                // Pipelined write: the address/data of the earlier beat
                // sit one stage further back than in the single case.
                w_paddr     = haddr2;
                w_pwdata    = hwdata1;
                w_pwrite    = 1'b1;
                w_pselx     = temp_selx;
                w_penable   = 1'b0;
                w_hreadyout = 1'b0;
            end
            ST_RENABLE, ST_WENABLE, ST_WENABLEP: begin
                w_penable   = 1'b1;
                w_hreadyout = w_en_hready;
            end
            default: begin
                w_pselx     = 3'b000;
                w_penable   = 1'b0;
                w_hreadyout = 1'b1;
            end
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_state     <= ST_IDLE;
            r_pselx     <= 3'b000;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_hreadyout <= 1'b1;
        end else begin
            r_state     <= w_next;
            r_pselx     <= w_pselx;
            r_penable   <= w_penable;
            r_pwrite    <= w_pwrite;
            r_paddr     <= w_paddr;
            r_pwdata    <= w_pwdata;
            r_hreadyout <= w_hreadyout;
        end
    end

    assign pselx     = r_pselx;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;
    assign hreadyout = r_hreadyout;

endmodule

// File: tb/tb_apb_fsm_controller.sv
// tb_apb_fsm_controller: directed bench for apb_fsm_controller.
// Covers reset, reads, writes, pipelined writes, write-then-read, reset abort.

module tb_apb_fsm_controller;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        valid;
    logic [31:0] haddr;
    logic [31:0] haddr1;
    logic [31:0] haddr2;
    logic [31:0] hwdata;
    logic [31:0] hwdata1;
    logic        hwrite;
    logic        hwrite_reg;
    logic [2:0]  temp_selx;
    logic        pready;
    logic [2:0]  pselx;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        hreadyout;

    int errors = 0;
    int checks = 0;

`ifdef APB_PREADY_EN
    localparam logic EN_HR  = 1'b0;
    localparam logic PR_DEF = 1'b1;
`else
    localparam logic EN_HR  = 1'b1;
    localparam logic PR_DEF = 1'b0;
`endif

    apb_fsm_controller #(.ADDR_W(32)) dut (
        .hclk       (hclk),
        .hreset     (hreset),
        .valid      (valid),
        .haddr      (haddr),
        .haddr1     (haddr1),
        .haddr2     (haddr2),
        .hwdata     (hwdata),
        .hwdata1    (hwdata1),
        .hwrite     (hwrite),
        .hwrite_reg (hwrite_reg),
        .temp_selx  (temp_selx),
        .pready     (pready),
        .pselx      (pselx),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .hreadyout  (hreadyout)
    );

    always #5 hclk = ~hclk;

    task automatic tick;
        @(posedge hclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [2:0] ps,
                              input logic pe, input logic pw,
                              input logic [31:0] pa, input logic [31:0] pd,
                              input logic hr);
        check({tag, ".pselx"}, {29'd0, pselx}, {29'd0, ps});
        check({tag, ".penable"}, {31'd0, penable}, {31'd0, pe});
        check({tag, ".pwrite"}, {31'd0, pwrite}, {31'd0, pw});
        check({tag, ".paddr"}, paddr, pa);
        check({tag, ".pwdata"}, pwdata, pd);
        check({tag, ".hreadyout"}, {31'd0, hreadyout}, {31'd0, hr});
    endtask

    initial begin
        hreset = 1'b1; valid = 1'b0; hwrite = 1'b0; hwrite_reg = 1'b0;
        haddr = 32'h0; haddr1 = 32'h0; haddr2 = 32'h0;
        hwdata = 32'h0; hwdata1 = 32'h0; temp_selx = 3'b000;
        pready = PR_DEF;
        tick;
        tick;
        expect_out("reset", 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

        // Single read
        hreset = 1'b0;
        valid = 1'b1; hwrite = 1'b0;
        haddr = 32'h8000_0010; temp_selx = 3'b001;
        tick;
        expect_out("rd.read", 3'b001, 1'b0, 1'b0, 32'h8000_0010, 32'h0, 1'b0);
        valid = 1'b0;
        tick;
        expect_out("rd.renable", 3'b001, 1'b1, 1'b0, 32'h8000_0010, 32'h0, EN_HR);
        tick;
        expect_out("rd.idle", 3'b000, 1'b0, 1'b0, 32'h8000_0010, 32'h0, 1'b1);

        // Single write
        valid = 1'b1; hwrite = 1'b1;
        haddr = 32'h8400_0004; temp_selx = 3'b010;
        tick;
        expect_out("wr.wwait", 3'b000, 1'b0, 1'b0, 32'h8000_0010, 32'h0, 1'b1);
        valid = 1'b0; hwrite = 1'b0; hwrite_reg = 1'b1;
        haddr1 = 32'h8400_0004; hwdata = 32'hA5A5_A5A5;
        haddr2 = 32'hDEAD_0002; hwdata1 = 32'hBEEF_0001;
        tick;
        expect_out("wr.write", 3'b010, 1'b0, 1'b1, 32'h8400_0004, 32'hA5A5_A5A5, 1'b1);
        tick;
        expect_out("wr.wenable", 3'b010, 1'b1, 1'b1, 32'h8400_0004, 32'hA5A5_A5A5, EN_HR);
        tick;
        expect_out("wr.idle", 3'b000, 1'b0, 1'b1, 32'h8400_0004, 32'hA5A5_A5A5, 1'b1);

        // Back-to-back writes
        valid = 1'b1; hwrite = 1'b1;
        haddr = 32'h8000_0000; temp_selx = 3'b001;
        tick;
        expect_out("b2b.wwait", 3'b000, 1'b0, 1'b1, 32'h8400_0004, 32'hA5A5_A5A5, 1'b1);
        valid = 1'b1; hwrite = 1'b1; hwrite_reg = 1'b1;
        haddr = 32'h8000_0004; haddr1 = 32'hDEAD_0001; haddr2 = 32'h8000_0000;
        hwdata = 32'hDEAD_D001; hwdata1 = 32'h1111_1111;
        tick;
        expect_out("b2b.writep", 3'b001, 1'b0, 1'b1, 32'h8000_0000, 32'h1111_1111, 1'b0);
        valid = 1'b0; hwrite = 1'b0;
        tick;
        expect_out("b2b.wenablep", 3'b001, 1'b1, 1'b1, 32'h8000_0000, 32'h1111_1111, EN_HR);
        hwrite_reg = 1'b1;
        haddr1 = 32'h8000_0004; hwdata = 32'h2222_2222;
        haddr2 = 32'hDEAD_0002; hwdata1 = 32'hDEAD_D002;
        tick;
        expect_out("b2b.write", 3'b001, 1'b0, 1'b1, 32'h8000_0004, 32'h2222_2222, 1'b1);
        tick;
        expect_out("b2b.wenable", 3'b001, 1'b1, 1'b1, 32'h8000_0004, 32'h2222_2222, EN_HR);
        tick;
        expect_out("b2b.idle", 3'b000, 1'b0, 1'b1, 32'h8000_0004, 32'h2222_2222, 1'b1);

        // Write followed by read
        valid = 1'b1; hwrite = 1'b1;
        haddr = 32'h8000_0008; temp_selx = 3'b010;
        tick;
        expect_out("wr2rd.wwait", 3'b000, 1'b0, 1'b1, 32'h8000_0004, 32'h2222_2222, 1'b1);
        valid = 1'b1; hwrite = 1'b0; hwrite_reg = 1'b1;
        haddr = 32'h8000_0020; haddr1 = 32'hDEAD_0003; haddr2 = 32'h8000_0008;
        hwdata = 32'hDEAD_D003; hwdata1 = 32'h3333_3333;
        tick;
        expect_out("wr2rd.writep", 3'b010, 1'b0, 1'b1, 32'h8000_0008, 32'h3333_3333, 1'b0);
        valid = 1'b0; hwrite = 1'b0;
        tick;
        expect_out("wr2rd.wenablep", 3'b010, 1'b1, 1'b1, 32'h8000_0008, 32'h3333_3333, EN_HR);
        hwrite_reg = 1'b0; temp_selx = 3'b100;
        tick;
        expect_out("wr2rd.read", 3'b100, 1'b0, 1'b0, 32'h8000_0020, 32'h3333_3333, 1'b0);
        tick;
        expect_out("wr2rd.renable", 3'b100, 1'b1, 1'b0, 32'h8000_0020, 32'h3333_3333, EN_HR);
        tick;
        expect_out("wr2rd.idle", 3'b000, 1'b0, 1'b0, 32'h8000_0020, 32'h3333_3333, 1'b1);

        // Unmapped read, then a write straight out of RENABLE
        valid = 1'b1; hwrite = 1'b0;
        haddr = 32'hF000_0000; temp_selx = 3'b000;
        tick;
        expect_out("unm.read", 3'b000, 1'b0, 1'b0, 32'hF000_0000, 32'h3333_3333, 1'b0);
        valid = 1'b1; hwrite = 1'b1;
        haddr = 32'h8000_0030; temp_selx = 3'b001;
        tick;
        expect_out("unm.renable", 3'b000, 1'b1, 1'b0, 32'hF000_0000, 32'h3333_3333, EN_HR);
        tick;
        expect_out("unm.wwait", 3'b000, 1'b0, 1'b0, 32'hF000_0000, 32'h3333_3333, 1'b1);
        valid = 1'b0; hwrite = 1'b0; hwrite_reg = 1'b1;
        haddr1 = 32'h8000_0030; hwdata = 32'h4444_4444;
        tick;
        expect_out("rst.write", 3'b001, 1'b0, 1'b1, 32'h8000_0030, 32'h4444_4444, 1'b1);
        tick;
        expect_out("rst.wenable", 3'b001, 1'b1, 1'b1, 32'h8000_0030, 32'h4444_4444, EN_HR);

        // Reset mid-transfer
        hreset = 1'b1; valid = 1'b1; hwrite = 1'b1;
        tick;
        expect_out("rst.abort", 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        hreset = 1'b0; valid = 1'b0; hwrite = 1'b0;
        tick;
        expect_out("rst.idle", 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

`ifdef APB_PREADY_EN
        // Slave stalls the enable phase for three cycles
        pready = 1'b0; valid = 1'b1; hwrite = 1'b0;
        haddr = 32'h8000_0040; temp_selx = 3'b001;
        tick;
        expect_out("stall.read", 3'b001, 1'b0, 1'b0, 32'h8000_0040, 32'h0, 1'b0);
        valid = 1'b0;
        tick;
        expect_out("stall.en1", 3'b001, 1'b1, 1'b0, 32'h8000_0040, 32'h0, 1'b0);
        tick;
        expect_out("stall.en2", 3'b001, 1'b1, 1'b0, 32'h8000_0040, 32'h0, 1'b0);
        tick;
        expect_out("stall.en3", 3'b001, 1'b1, 1'b0, 32'h8000_0040, 32'h0, 1'b0);
        pready = 1'b1;
        tick;
        expect_out("stall.idle", 3'b000, 1'b0, 1'b0, 32'h8000_0040, 32'h0, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
